// File: rtl/screen_pkg.sv
// Shared definitions for the 160x120, 3-bit-colour screen controller.
package screen_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int FRAME_PIXELS = SCREEN_W * SCREEN_H;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int ROM_ADDR_W = 15;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [2:0] {
    S_TITLE_FILL,
    S_TITLE_HOLD,
    S_CLEAR_FILL,
    S_GAME,
    S_OVER_FILL,
    S_OVER_HOLD
  } state_t;

  function automatic logic is_fill(input state_t s);
    return (s == S_TITLE_FILL) || (s == S_CLEAR_FILL) || (s == S_OVER_FILL);
  endfunction

endpackage

// File: rtl/raster_scanner.sv
// Column/row/linear-address raster counters for full-frame fills, x fastest.
module raster_scanner #(
  parameter int W   = 160,
  parameter int H   = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int A_W = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           active_i,
  output logic [X_W-1:0] col_o,
  output logic [Y_W-1:0] row_o,
  output logic [A_W-1:0] addr_o,
  output logic           last_o
);

  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [A_W-1:0] addr_q, addr_d;
  logic           col_last, row_last;

  assign col_last = (col_q == X_W'(W - 1));
  assign row_last = (row_q == Y_W'(H - 1));
  assign last_o   = active_i && col_last && row_last;

  // The address advances alongside col/row, so no multiply or divide is needed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (start_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (active_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + Y_W'(1);
      end else begin
        col_d = col_q + X_W'(1);
      end
      addr_d = (col_last && row_last) ? '0 : addr_q + A_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller: title/clear/game/game-over sequencing, raster fills and
// arbitration of the single VGA plot port.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int         WIDTH        = SCREEN_W,
  parameter int         HEIGHT       = SCREEN_H,
  parameter int         ADDR_W       = ROM_ADDR_W,
  parameter logic [2:0] OVER_COLOUR  = RED,
  parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_key,
  input  logic              game_over,
  input  logic              game_req,
  input  logic [7:0]        game_x,
  input  logic [6:0]        game_y,
  input  logic [2:0]        game_colour,
  output logic              game_ack,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [2:0]        rom_q,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              fill_done,
  output logic              in_game
);

  state_t state_q, state_d;

  logic              fill_active, scan_start, scan_last;
  logic [7:0]        scan_col;
  logic [6:0]        scan_row;
  logic [ADDR_W-1:0] scan_addr;

  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       src_rom_q, src_rom_d;
  logic       done_q, done_d;

  assign fill_active = is_fill(state_q);

  raster_scanner #(
    .W   (WIDTH),
    .H   (HEIGHT),
    .X_W (8),
    .Y_W (7),
    .A_W (ADDR_W)
  ) u_scanner (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (scan_start),
    .active_i (fill_active),
    .col_o    (scan_col),
    .row_o    (scan_row),
    .addr_o   (scan_addr),
    .last_o   (scan_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TITLE_FILL: if (scan_last) state_d = S_TITLE_HOLD;
      S_TITLE_HOLD: if (start_key) state_d = S_CLEAR_FILL;
      S_CLEAR_FILL: if (scan_last) state_d = S_GAME;
      S_GAME:       if (game_over) state_d = S_OVER_FILL;
      S_OVER_FILL:  if (scan_last) state_d = S_OVER_HOLD;
      S_OVER_HOLD:  if (start_key) state_d = S_TITLE_FILL;
      default:      state_d = S_TITLE_FILL;
    endcase
    scan_start = is_fill(state_d) && (state_d != state_q);
  end

  assign game_ack = (state_q == S_GAME) && game_req && !game_over;

  // One pixel source per state feeds a single registered plot stage.
  always_comb begin
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    src_rom_d = 1'b0;
    done_d    = scan_last;
    unique case (state_q)
      S_TITLE_FILL: begin
        plot_d    = 1'b1;
        x_d       = scan_col;
        y_d       = scan_row;
        src_rom_d = 1'b1;
      end
      S_CLEAR_FILL: begin
        plot_d   = 1'b1;
        x_d      = scan_col;
        y_d      = scan_row;
        colour_d = CLEAR_COLOUR;
      end
      S_OVER_FILL: begin
        plot_d   = 1'b1;
        x_d      = scan_col;
        y_d      = scan_row;
        colour_d = OVER_COLOUR;
      end
      S_GAME: begin
        if (game_ack) begin
          plot_d   = 1'b1;
          x_d      = game_x;
          y_d      = game_y;
          colour_d = game_colour;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_TITLE_FILL;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      src_rom_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      src_rom_q <= src_rom_d;
      done_q    <= done_d;
    end
  end

  assign rom_address = (state_q == S_TITLE_FILL) ? scan_addr : '0;

  // The title ROM's own output register supplies the colour in the plot cycle,
  // keeping title pixels aligned with the registered coordinates.
  assign vga_colour = src_rom_q ? rom_q : colour_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_plot   = plot_q;
  assign fill_done  = done_q;
  assign in_game    = (state_q == S_GAME);

endmodule
